// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch widths, reset PC and the fetch-queue entry.
package cpu_pkg;

    localparam int INST_W    = 32;
    localparam int PC_W      = 32;
    localparam int ROM_IDX_W = 8;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Word index into inst_rom; wraps modulo the ROM size by truncation.
    function automatic logic [ROM_IDX_W-1:0] rom_index(input logic [PC_W-1:0] pc);
        return pc[ROM_IDX_W+1:2];
    endfunction

endpackage

// File: rtl/inst_prefetch_buf_if.sv
// ROM read port plus the fetch-side valid/ready channel of the prefetch buffer.
interface inst_prefetch_buf_if;
    import cpu_pkg::*;

    logic [ROM_IDX_W-1:0] rom_addr;
    logic [INST_W-1:0]    rom_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [PC_W-1:0]      out_pc;
    logic [INST_W-1:0]    out_inst;

    modport master (
        output rom_addr, out_valid, out_pc, out_inst,
        input  rom_data, out_ready
    );

    modport slave (
        input  rom_addr, out_valid, out_pc, out_inst,
        output rom_data, out_ready
    );

endinterface

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of fetch entries; control state resets, storage does not.
module prefetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             din,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    fetch_entry_t  mem [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_prefetch_buf.sv
// Instruction prefetch queue: sequential ROM fetch with credit-based issue,
// one read in flight, redirect on flush, valid/ready delivery of {pc, inst}.
module inst_prefetch_buf
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic [PC_W-1:0]        flush_pc,
    inst_prefetch_buf_if.master    bus,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] req_pc;
    logic            req_pend;
    logic            issue;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    fetch_entry_t    entry;
    fetch_entry_t    head;
    logic            unused_flush_pc_lsb;

    assign unused_flush_pc_lsb = ^flush_pc[1:0];

    // The in-flight read reserves a slot so the FIFO can never overflow.
    assign credit = {1'b0, count} + {{CW{1'b0}}, req_pend};
    assign issue  = !flush && (credit < (CW+1)'(DEPTH));
    assign push   = req_pend && !flush;
    assign pop    = bus.out_valid && bus.out_ready && !flush;
    assign entry  = '{pc: req_pc, inst: bus.rom_data};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc <= RESET_PC;
            req_pend <= 1'b0;
        end else if (flush) begin
            fetch_pc <= {flush_pc[PC_W-1:2], 2'b00};
            req_pend <= 1'b0;
        end else begin
            if (issue) fetch_pc <= fetch_pc + 32'd4;
            req_pend <= issue;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) req_pc <= fetch_pc;
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .clear  (flush),
        .din    (entry),
        .head   (head),
        .count  (count)
    );

    // Outputs derive only from registered state; storage is masked when empty.
    assign bus.rom_addr  = rom_index(fetch_pc);
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = bus.out_valid ? head.pc   : '0;
    assign bus.out_inst  = bus.out_valid ? head.inst : '0;
    assign occupancy     = count;

endmodule
